// File: rtl/ahb_resp_pkg.sv
// Shared AHB encodings, FSM state type and sizing constants for the
// single-port SRAM responder.
package ahb_resp_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Reads need one cycle more than writes, so the counter must hold WAIT_STATES_MAX+1.
  localparam int WAIT_STATES_MAX = 7;
  localparam int WAIT_CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } resp_state_e;

endpackage

// File: rtl/ahb_mem_responder_if.sv
// AHB-Lite slave-side bus bundle between the interconnect and the memory responder.
interface ahb_mem_responder_if;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [31:0] HWDATAS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic        HRESPS;
  logic [31:0] HRDATAS;

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HWDATAS, HREADYS,
    input  HREADYOUTS, HRESPS, HRDATAS
  );

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HWDATAS, HREADYS,
    output HREADYOUTS, HRESPS, HRDATAS
  );
endinterface

// File: rtl/ahb_resp_bytelane.sv
// Little-endian byte-lane decode and alignment check for one AHB transfer.
module ahb_resp_bytelane
  import ahb_resp_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       misaligned
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    be         = 4'b0000;
    misaligned = 1'b0;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      HSIZE_WORD: begin
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_mem_responder.sv
// AHB-Lite slave fronting a 1-cycle-latency synchronous SRAM, with
// configurable wait states and a two-cycle ERROR response.
module ahb_mem_responder
  import ahb_resp_pkg::*;
#(
  parameter int MEM_AW      = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahb_mem_responder_if.slave  bus,
  output logic                mem_req,
  output logic                mem_we,
  output logic [MEM_AW-3:0]   mem_addr,
  output logic [3:0]          mem_be,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  if (WAIT_STATES < 0 || WAIT_STATES > WAIT_STATES_MAX) begin : g_bad_wait_states
    $error("ahb_mem_responder: WAIT_STATES out of range");
  end

  localparam logic [WAIT_CNT_W-1:0] CNT_WR = WAIT_CNT_W'(WAIT_STATES);
  localparam logic [WAIT_CNT_W-1:0] CNT_RD = WAIT_CNT_W'(WAIT_STATES + 1);

  resp_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    we_q;
  logic [MEM_AW-3:0]       addr_q;
  logic [3:0]              be_q;
  logic                    first_q;
  logic                    rd_live_q;
  logic [31:0]             rdata_q;

  logic [3:0] be_dec;
  logic       misaligned;
  logic       xfer_err;
  logic       accept;
  logic       hready;
  logic       hresp;
  logic       rd_final;

  ahb_resp_bytelane u_bytelane (
    .size      (bus.HSIZES),
    .addr_lo   (bus.HADDRS[1:0]),
    .be        (be_dec),
    .misaligned(misaligned)
  );

  assign xfer_err = ((bus.HADDRS >> MEM_AW) != 32'd0) || (bus.HSIZES > HSIZE_WORD) || misaligned;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hready  = 1'b1;
    hresp   = HRESP_OKAY;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_DATA: begin
        hready = (cnt_q == '0);
        if (cnt_q != '0) cnt_d   = cnt_q - WAIT_CNT_W'(1);
        else             state_d = ST_IDLE;
      end
      ST_ERR1: begin
        hready  = 1'b0;
        hresp   = HRESP_ERROR;
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        hresp   = HRESP_ERROR;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Our own ready gates acceptance so ERR1 and wait cycles ignore a misbehaving master.
    accept = bus.HSELS && bus.HREADYS && hready &&
             (bus.HTRANSS == HTRANS_NONSEQ || bus.HTRANSS == HTRANS_SEQ);
    if (accept) begin
      state_d = xfer_err ? ST_ERR1 : ST_DATA;
      cnt_d   = xfer_err ? '0 : (bus.HWRITES ? CNT_WR : CNT_RD);
    end
  end

  always_ff @(posedge HCLK) begin
    // NOTE: non-blocking assignments only in clocked blocks; reset is synchronous here.
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= 4'b0000;
      first_q   <= 1'b0;
      rd_live_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      first_q   <= accept && !xfer_err;
      rd_live_q <= mem_req && !mem_we;
      if (rd_live_q) rdata_q <= mem_rdata;
      if (accept) begin
        we_q   <= bus.HWRITES;
        addr_q <= bus.HADDRS[MEM_AW-1:2];
        be_q   <= be_dec;
      end
    end
  end

  assign mem_req   = (state_q == ST_DATA) && first_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = bus.HWDATAS;

  // With zero wait states the SRAM output is still live in the final cycle.
  assign rd_final       = (state_q == ST_DATA) && !we_q && (cnt_q == '0);
  assign bus.HRDATAS    = rd_final ? (rd_live_q ? mem_rdata : rdata_q) : 32'd0;
  assign bus.HREADYOUTS = hready;
  assign bus.HRESPS     = hresp;

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Directed bench for ahb_mem_responder: one zero-wait and one two-wait instance,
// each behind its own SRAM model, checked against a response and a memory-op scoreboard.
module tb_ahb_mem_responder;
  import ahb_resp_pkg::*;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  logic HRESETn;

  int checks   = 0;
  int failures = 0;

  ahb_mem_responder_if bus0 ();
  ahb_mem_responder_if bus1 ();

  logic        which;
  logic        t_sel, t_write;
  logic [31:0] t_addr, t_wdata;
  logic [1:0]  t_trans;
  logic [2:0]  t_size;

  assign bus0.HSELS   = t_sel && (which == 1'b0);
  assign bus1.HSELS   = t_sel && (which == 1'b1);
  assign bus0.HADDRS  = t_addr;   assign bus1.HADDRS  = t_addr;
  assign bus0.HTRANSS = t_trans;  assign bus1.HTRANSS = t_trans;
  assign bus0.HWRITES = t_write;  assign bus1.HWRITES = t_write;
  assign bus0.HSIZES  = t_size;   assign bus1.HSIZES  = t_size;
  assign bus0.HWDATAS = t_wdata;  assign bus1.HWDATAS = t_wdata;
  assign bus0.HREADYS = bus0.HREADYOUTS;
  assign bus1.HREADYS = bus1.HREADYOUTS;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [11:0] m0_addr, m1_addr;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;

  ahb_mem_responder #(.MEM_AW(14), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0),
    .mem_req(m0_req), .mem_we(m0_we), .mem_addr(m0_addr), .mem_be(m0_be),
    .mem_wdata(m0_wdata), .mem_rdata(m0_rdata)
  );

  ahb_mem_responder #(.MEM_AW(14), .WAIT_STATES(2)) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1),
    .mem_req(m1_req), .mem_we(m1_we), .mem_addr(m1_addr), .mem_be(m1_be),
    .mem_wdata(m1_wdata), .mem_rdata(m1_rdata)
  );

  logic        o_ready, o_resp, o_req;
  logic [31:0] o_rdata;
  logic [11:0] o_addr;
  logic [3:0]  o_be;
  assign o_ready = which ? bus1.HREADYOUTS : bus0.HREADYOUTS;
  assign o_resp  = which ? bus1.HRESPS     : bus0.HRESPS;
  assign o_rdata = which ? bus1.HRDATAS    : bus0.HRDATAS;
  assign o_req   = which ? m1_req  : m0_req;
  assign o_addr  = which ? m1_addr : m0_addr;
  assign o_be    = which ? m1_be   : m0_be;

  // Synchronous SRAM models, 1-cycle read latency.
  logic [31:0] sram0 [0:4095];
  logic [31:0] sram1 [0:4095];
  always @(posedge HCLK) begin
    if (m0_req === 1'b1) begin
      for (int b = 0; b < 4; b++)
        if (m0_we && m0_be[b]) sram0[m0_addr][8*b +: 8] <= m0_wdata[8*b +: 8];
      m0_rdata <= sram0[m0_addr];
    end
  end
  always @(posedge HCLK) begin
    if (m1_req === 1'b1) begin
      for (int b = 0; b < 4; b++)
        if (m1_we && m1_be[b]) sram1[m1_addr][8*b +: 8] <= m1_wdata[8*b +: 8];
      m1_rdata <= sram1[m1_addr];
    end
  end

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } memop_t;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          len;
  } rsp_t;

  memop_t      mq0[$];
  memop_t      mq1[$];
  rsp_t        rq[$];
  logic [31:0] shadow [0:1][0:4095];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge HCLK) begin
    if (m0_req === 1'b1) begin
      if (mq0.size() == 0) check("mem0_unexpected_req", 64'd1, 64'd0);
      else check("mem0_op", 64'({m0_we, m0_addr, m0_be, m0_wdata}), 64'(mq0.pop_front()));
    end
    if (m1_req === 1'b1) begin
      if (mq1.size() == 0) check("mem1_unexpected_req", 64'd1, 64'd0);
      else check("mem1_op", 64'({m1_we, m1_addr, m1_be, m1_wdata}), 64'(mq1.pop_front()));
    end
  end

  function automatic logic [3:0] exp_be(input logic [2:0] size, input logic [31:0] addr);
    case (size)
      3'd0:    return 4'b0001 << addr[1:0];
      3'd1:    return addr[1] ? 4'b1100 : 4'b0011;
      3'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic exp_err(input logic [2:0] size, input logic [31:0] addr);
    return (addr[31:14] != 18'd0) || (size > 3'd2) ||
           (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
  endfunction

  task automatic push_op(input logic w, input logic we, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata);
    memop_t op;
    op = '{we: we, addr: addr[13:2], be: exp_be(size, addr), wdata: wdata};
    if (w) mq1.push_back(op); else mq0.push_back(op);
    if (we)
      for (int b = 0; b < 4; b++)
        if (op.be[b]) shadow[w][addr[13:2]][8*b +: 8] = wdata[8*b +: 8];
  endtask

  task automatic drive_aphase(input logic [31:0] addr, input logic wr, input logic [2:0] size);
    t_sel = 1'b1; t_trans = HTRANS_NONSEQ; t_addr = addr; t_write = wr; t_size = size;
  endtask

  task automatic go_idle(input logic [31:0] wdata);
    t_sel = 1'b0; t_trans = HTRANS_IDLE; t_wdata = wdata;
  endtask

  task automatic next_cycle();
    @(posedge HCLK); #1;
  endtask

  // Full single transfer from an idle bus; the response is scoreboarded.
  task automatic run_xfer(input logic w, input logic [31:0] addr, input logic wr,
                          input logic [2:0] size, input logic [31:0] wdata, input string tag);
    int          ws, n;
    logic        err, done, resp_seen;
    logic [31:0] rdata_seen;
    rsp_t        e;
    ws = w ? 2 : 0;
    which = w;
    err = exp_err(size, addr);
    drive_aphase(addr, wr, size);
    if (err)     rq.push_back('{resp: 1'b1, rdata: 32'd0, len: 2});
    else if (wr) rq.push_back('{resp: 1'b0, rdata: 32'd0, len: 1 + ws});
    else         rq.push_back('{resp: 1'b0, rdata: shadow[w][addr[13:2]], len: 2 + ws});
    if (!err) push_op(w, wr, addr, size, wr ? wdata : 32'd0);
    next_cycle();
    go_idle(wr ? wdata : 32'd0);
    n = 0; done = 1'b0; resp_seen = 1'bx; rdata_seen = 'x;
    while (!done && n < 20) begin
      @(negedge HCLK);
      n++;
      if (err) check({tag, "_err_resp"}, 64'(o_resp), 64'd1);
      if (o_ready === 1'b1) begin
        done = 1'b1; resp_seen = o_resp; rdata_seen = o_rdata;
      end
      next_cycle();
    end
    if (!done) check({tag, "_timeout"}, 64'd0, 64'd1);
    e = rq.pop_front();
    check({tag, "_len"},   64'(n),          64'(e.len));
    check({tag, "_resp"},  64'(resp_seen),  64'(e.resp));
    check({tag, "_rdata"}, 64'(rdata_seen), 64'(e.rdata));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0;
    which = 1'b0;
    go_idle(32'd0);
    t_addr = 32'd0; t_write = 1'b0; t_size = 3'd0;
    for (int i = 0; i < 4096; i++) begin shadow[0][i] = 32'd0; shadow[1][i] = 32'd0; end
    repeat (3) @(posedge HCLK);
    #1;

    @(negedge HCLK);
    check("rst_ready0", 64'(bus0.HREADYOUTS), 64'd1);
    check("rst_resp0",  64'(bus0.HRESPS),     64'd0);
    check("rst_rdata0", 64'(bus0.HRDATAS),    64'd0);
    check("rst_req0",   64'(m0_req),          64'd0);
    check("rst_ready1", 64'(bus1.HREADYOUTS), 64'd1);
    check("rst_req1",   64'(m1_req),          64'd0);
    next_cycle();
    HRESETn = 1'b1;
    next_cycle();

    // Zero-wait word write: SRAM strobe and ready in the same cycle.
    which = 1'b0;
    drive_aphase(32'h10, 1'b1, HSIZE_WORD);
    push_op(1'b0, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
    next_cycle();
    go_idle(32'hDEADBEEF);
    @(negedge HCLK);
    check("w10_req",   64'(o_req),   64'd1);
    check("w10_ready", 64'(o_ready), 64'd1);
    check("w10_addr",  64'(o_addr),  64'd4);
    check("w10_be",    64'(o_be),    64'hF);
    next_cycle();

    run_xfer(1'b0, 32'h10,   1'b0, HSIZE_WORD, 32'd0,          "r10_ws0");
    run_xfer(1'b0, 32'h3FFC, 1'b1, HSIZE_WORD, 32'hA5A50001,   "w_top");
    run_xfer(1'b0, 32'h3FFC, 1'b0, HSIZE_WORD, 32'd0,          "r_top");
    run_xfer(1'b0, 32'h20,   1'b1, HSIZE_WORD, 32'h0,          "w20_clr");
    run_xfer(1'b0, 32'h22,   1'b1, HSIZE_HALF, 32'h12345678,   "w22_half");
    run_xfer(1'b0, 32'h20,   1'b0, HSIZE_WORD, 32'd0,          "r20_half");
    run_xfer(1'b0, 32'h3,    1'b1, HSIZE_HALF, 32'h55AA55AA,   "err_half_mis");
    run_xfer(1'b0, 32'h10,   1'b1, 3'd3,       32'h11111111,   "err_size3");
    run_xfer(1'b0, 32'h12,   1'b0, HSIZE_WORD, 32'd0,          "err_word_mis");

    // Out-of-window error, master drops to IDLE in ERR1, new OKAY accepted in ERR2.
    which = 1'b0;
    drive_aphase(32'h0000_4000, 1'b0, HSIZE_WORD);
    next_cycle();
    t_trans = HTRANS_IDLE;
    @(negedge HCLK);
    check("oow_err1_ready", 64'(o_ready), 64'd0);
    check("oow_err1_resp",  64'(o_resp),  64'd1);
    next_cycle();
    drive_aphase(32'h20, 1'b1, HSIZE_WORD);
    push_op(1'b0, 1'b1, 32'h20, HSIZE_WORD, 32'hCAFEF00D);
    @(negedge HCLK);
    check("oow_err2_ready", 64'(o_ready), 64'd1);
    check("oow_err2_resp",  64'(o_resp),  64'd1);
    check("oow_err2_req",   64'(o_req),   64'd0);
    next_cycle();
    go_idle(32'hCAFEF00D);
    @(negedge HCLK);
    check("b2b_ok_req",   64'(o_req),   64'd1);
    check("b2b_ok_ready", 64'(o_ready), 64'd1);
    check("b2b_ok_resp",  64'(o_resp),  64'd0);
    next_cycle();
    run_xfer(1'b0, 32'h20, 1'b0, HSIZE_WORD, 32'd0, "r20_after_err");

    // Back-to-back byte writes on consecutive cycles.
    run_xfer(1'b0, 32'h0, 1'b1, HSIZE_WORD, 32'h11223344, "w0_word");
    which = 1'b0;
    drive_aphase(32'h1, 1'b1, HSIZE_BYTE);
    push_op(1'b0, 1'b1, 32'h1, HSIZE_BYTE, 32'h0000AA00);
    next_cycle();
    drive_aphase(32'h2, 1'b1, HSIZE_BYTE);
    t_wdata = 32'h0000AA00;
    push_op(1'b0, 1'b1, 32'h2, HSIZE_BYTE, 32'h00BB0000);
    @(negedge HCLK);
    check("b2b_b1_req", 64'(o_req), 64'd1);
    check("b2b_b1_be",  64'(o_be),  64'b0010);
    next_cycle();
    go_idle(32'h00BB0000);
    @(negedge HCLK);
    check("b2b_b2_req", 64'(o_req), 64'd1);
    check("b2b_b2_be",  64'(o_be),  64'b0100);
    next_cycle();
    run_xfer(1'b0, 32'h0, 1'b0, HSIZE_WORD, 32'd0, "r0_bytes");

    // Two-wait-state instance.
    run_xfer(1'b1, 32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF, "w10_ws2");
    run_xfer(1'b1, 32'h10, 1'b0, HSIZE_WORD, 32'd0,        "r10_ws2");

    // Reset during the second wait cycle of a read.
    which = 1'b1;
    drive_aphase(32'h10, 1'b0, HSIZE_WORD);
    push_op(1'b1, 1'b0, 32'h10, HSIZE_WORD, 32'd0);
    next_cycle();
    go_idle(32'd0);
    @(negedge HCLK);
    check("rstmid_d0_ready", 64'(o_ready), 64'd0);
    next_cycle();
    HRESETn = 1'b0;
    drive_aphase(32'h14, 1'b1, HSIZE_WORD);
    next_cycle();
    @(negedge HCLK);
    check("rstmid_ready", 64'(o_ready), 64'd1);
    check("rstmid_rdata", 64'(o_rdata), 64'd0);
    check("rstmid_resp",  64'(o_resp),  64'd0);
    check("rstmid_req",   64'(o_req),   64'd0);
    next_cycle();
    HRESETn = 1'b1;
    go_idle(32'd0);
    @(negedge HCLK);
    check("rstrel_ready", 64'(o_ready), 64'd1);
    check("rstrel_req",   64'(o_req),   64'd0);
    next_cycle();
    run_xfer(1'b1, 32'h10, 1'b0, HSIZE_WORD, 32'd0, "r10_after_rst");

    repeat (2) next_cycle();
    check("mem0_queue_drained", 64'(mq0.size()), 64'd0);
    check("mem1_queue_drained", 64'(mq1.size()), 64'd0);
    check("rsp_queue_drained",  64'(rq.size()),  64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
